// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//
// Purpose
//   Initiator side of the word-wide data memory port. Takes one load or
//   store request at a time from the pipeline. Loads read one word and return
//   the addressed lane, either sign- or zero-extended. Word stores write
//   straight through. Byte and halfword stores read the word first, merge the
//   new lane into it and then write the whole word back.
//
// Handshake semantics (request and response side alike)
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   The request side is ready only in IDLE, so at most one request is in
//   flight. The response stays valid, with respData and respErr held stable,
//   until the consumer raises respReady.
//
// Ports
//   clk, rst_n            clock and asynchronous active-low reset
//   reqValid/reqReady     request handshake
//   reqWrite              1 = store, 0 = load
//   reqSize               0 byte, 1 half, 2 word, 3 illegal
//   reqSigned             sign-extend sub-word loads
//   reqAddr               byte address, little-endian lanes
//   reqWrData             store data, right-justified
//   respValid/respReady   response handshake
//   respData              load result (0 for stores and errors)
//   respErr               misaligned or illegal request
//   memWr*                clocked write port of the data memory
//   memRd*                combinational read port of the data memory
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int WORD_ADDR_W = 5,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   reqValid,
    output logic                   reqReady,
    input  logic                   reqWrite,
    input  logic [1:0]             reqSize,
    input  logic                   reqSigned,
    input  logic [WORD_ADDR_W+1:0] reqAddr,
    input  logic [31:0]            reqWrData,
    output logic                   respValid,
    input  logic                   respReady,
    output logic [31:0]            respData,
    output logic                   respErr,
    output logic                   memWrEnable,
    output logic [WORD_ADDR_W-1:0] memWrAddress,
    output logic [31:0]            memWrData,
    output logic                   memRdEnable,
    output logic [WORD_ADDR_W-1:0] memRdAddress,
    input  logic [31:0]            memRdData
);

    localparam int AW = WORD_ADDR_W + 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STORE  = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          signed_q, signed_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   merge_q, merge_d;
    logic [31:0]   resp_data_q, resp_data_d;
    logic          resp_err_q, resp_err_d;

    // Alignment decode on the incoming request. With checking disabled the
    // offending low address bits are masked, and size 3 is handled as a word.
    logic          req_err;
    logic [AW-1:0] req_addr_eff;
    logic [1:0]    req_size_eff;

    always_comb begin
        req_err      = 1'b0;
        req_addr_eff = reqAddr;
        req_size_eff = reqSize;
        case (reqSize)
            2'd1: begin
                if (ALIGN_CHECK) req_err = reqAddr[0];
                else             req_addr_eff[0] = 1'b0;
            end
            2'd2: begin
                if (ALIGN_CHECK) req_err = |reqAddr[1:0];
                else             req_addr_eff[1:0] = 2'b00;
            end
            2'd3: begin
                if (ALIGN_CHECK) begin
                    req_err = 1'b1;
                end else begin
                    req_addr_eff[1:0] = 2'b00;
                    req_size_eff      = 2'd2;
                end
            end
            default: ;
        endcase
    end

    // Lane extraction and extension of the word returned by memory.
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;

    always_comb begin
        case (addr_q[1:0])
            2'd0:    rd_byte = memRdData[7:0];
            2'd1:    rd_byte = memRdData[15:8];
            2'd2:    rd_byte = memRdData[23:16];
            default: rd_byte = memRdData[31:24];
        endcase
        rd_half = addr_q[1] ? memRdData[31:16] : memRdData[15:0];
        case (size_q)
            2'd0:    load_val = {{24{signed_q & rd_byte[7]}}, rd_byte};
            2'd1:    load_val = {{16{signed_q & rd_half[15]}}, rd_half};
            default: load_val = memRdData;
        endcase
    end

    // Merge of the store lane into the word read back during RMW_RD.
    logic [31:0] merged;

    always_comb begin
        merged = merge_q;
        if (size_q == 2'd0) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0]  = wdata_q[15:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        signed_d    = signed_q;
        wdata_d     = wdata_q;
        merge_d     = merge_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (reqValid) begin
                    addr_d      = req_addr_eff;
                    size_d      = req_size_eff;
                    signed_d    = reqSigned;
                    wdata_d     = reqWrData;
                    // Response registers are rewritten on every accept so
                    // stores and errors report 0 data.
                    resp_data_d = 32'd0;
                    resp_err_d  = req_err;
                    if (req_err)                   state_d = S_RESP;
                    else if (!reqWrite)            state_d = S_LOAD;
                    else if (req_size_eff == 2'd2) state_d = S_STORE;
                    else                           state_d = S_RMW_RD;
                end
            end
            S_LOAD: begin
                resp_data_d = load_val;
                state_d     = S_RESP;
            end
            S_STORE:  state_d = S_RESP;
            S_RMW_RD: begin
                merge_d = memRdData;
                state_d = S_RMW_WR;
            end
            S_RMW_WR: state_d = S_RESP;
            S_RESP: begin
                if (respReady) state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            size_q      <= 2'd0;
            signed_q    <= 1'b0;
            wdata_q     <= 32'd0;
            merge_q     <= 32'd0;
            resp_data_q <= 32'd0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            wdata_q     <= wdata_d;
            merge_q     <= merge_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // Moore outputs, decoded from the state register only.
    assign reqReady     = (state_q == S_IDLE);
    assign respValid    = (state_q == S_RESP);
    assign respData     = resp_data_q;
    assign respErr      = resp_err_q;
    assign memRdEnable  = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    assign memWrEnable  = (state_q == S_STORE) || (state_q == S_RMW_WR);
    assign memRdAddress = addr_q[AW-1:2];
    assign memWrAddress = addr_q[AW-1:2];
    assign memWrData    = (state_q == S_STORE)  ? wdata_q :
                          (state_q == S_RMW_WR) ? merged  : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
//
// Bench for load_store_unit. A memory model answers the DUT's memory port.
// A byte-level reference model predicts each response, the enable pattern
// cycle by cycle and the word written to memory. Directed requests pin known
// literal values. Randomized requests then exercise the rest.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int WAW = 5;
    localparam int AW  = WAW + 2;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            reqValid = 1'b0;
    logic            reqReady;
    logic            reqWrite = 1'b0;
    logic [1:0]      reqSize = 2'd0;
    logic            reqSigned = 1'b0;
    logic [AW-1:0]   reqAddr = '0;
    logic [31:0]     reqWrData = 32'd0;
    logic            respValid;
    logic            respReady = 1'b1;
    logic [31:0]     respData;
    logic            respErr;
    logic            memWrEnable;
    logic [WAW-1:0]  memWrAddress;
    logic [31:0]     memWrData;
    logic            memRdEnable;
    logic [WAW-1:0]  memRdAddress;
    logic [31:0]     memRdData;

    always #5 clk = ~clk;

    load_store_unit #(.WORD_ADDR_W(WAW), .ALIGN_CHECK(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .reqWrite     (reqWrite),
        .reqSize      (reqSize),
        .reqSigned    (reqSigned),
        .reqAddr      (reqAddr),
        .reqWrData    (reqWrData),
        .respValid    (respValid),
        .respReady    (respReady),
        .respData     (respData),
        .respErr      (respErr),
        .memWrEnable  (memWrEnable),
        .memWrAddress (memWrAddress),
        .memWrData    (memWrData),
        .memRdEnable  (memRdEnable),
        .memRdAddress (memRdAddress),
        .memRdData    (memRdData)
    );

    function automatic logic [31:0] seed_word(input int i);
        return (32'h1357_9BDF * (i + 1)) ^ 32'hA5C3_0F1E;
    endfunction

    // ---------------- environment memory ----------------
    logic [31:0] env_mem [0:31];
    bit          env_seeded = 1'b0;

    assign memRdData = env_mem[memRdAddress];

    always @(posedge clk) begin
        if (!env_seeded) begin
            for (int i = 0; i < 32; i++) env_mem[i] <= seed_word(i);
            env_seeded <= 1'b1;
        end else if (memWrEnable) begin
            env_mem[memWrAddress] <= memWrData;
        end
    end

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    logic [7:0]  ref_bytes [0:127];
    bit          ref_seeded = 1'b0;
    bit          busy = 1'b0;
    bit          seen = 1'b0;
    int          lat = 0;
    int          last_lat = 0;
    int          wr_pulses = 0;
    int          rd_pulses = 0;
    bit          e_err, e_load, e_sw, e_rmw;
    int          e_lat;
    logic [31:0] e_data, e_word;
    logic [WAW-1:0] e_wa;
    int          pend_a, pend_n;
    logic [31:0] pend_d;
    logic [31:0] held_data = 32'd0;
    logic        held_err = 1'b0;
    logic [31:0] exp_resp_q [$];

    always @(negedge clk) begin
        int a, nb, off;
        logic [31:0] v, sw, wd;
        logic [7:0]  bt;
        bit exp_rd, exp_wr;
        if (!ref_seeded) begin
            for (int i = 0; i < 32; i++) begin
                sw = seed_word(i);
                for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = sw[8*b +: 8];
            end
            ref_seeded = 1'b1;
        end
        if (!rst_n) begin
            chk("rst_reqReady", {31'd0, reqReady}, 32'd1);
            chk("rst_respValid", {31'd0, respValid}, 32'd0);
            chk("rst_respData", respData, 32'd0);
            chk("rst_respErr", {31'd0, respErr}, 32'd0);
            chk("rst_memWrEnable", {31'd0, memWrEnable}, 32'd0);
            chk("rst_memRdEnable", {31'd0, memRdEnable}, 32'd0);
            chk("rst_memWrAddress", {27'd0, memWrAddress}, 32'd0);
            chk("rst_memRdAddress", {27'd0, memRdAddress}, 32'd0);
            chk("rst_memWrData", memWrData, 32'd0);
            busy      = 1'b0;
            held_data = 32'd0;
            held_err  = 1'b0;
            exp_resp_q.delete();
        end else begin
            chk("reqReady", {31'd0, reqReady}, {31'd0, !busy});
            chk("en_exclusive", {31'd0, memWrEnable & memRdEnable}, 32'd0);
            if (memWrEnable) wr_pulses++;
            if (memRdEnable) rd_pulses++;
            if (busy) begin
                lat++;
                exp_rd = !e_err && (lat == 1) && (e_load || e_rmw);
                exp_wr = !e_err && (((lat == 1) && e_sw) || ((lat == 2) && e_rmw));
                chk("memRdEnable", {31'd0, memRdEnable}, {31'd0, exp_rd});
                chk("memWrEnable", {31'd0, memWrEnable}, {31'd0, exp_wr});
                if (exp_rd) chk("memRdAddress", {27'd0, memRdAddress}, {27'd0, e_wa});
                if (exp_wr) begin
                    chk("memWrAddress", {27'd0, memWrAddress}, {27'd0, e_wa});
                    chk("memWrData", memWrData, e_word);
                end
                chk("respValid", {31'd0, respValid}, {31'd0, lat >= e_lat});
                if (respValid) begin
                    if (!seen) begin
                        seen     = 1'b1;
                        last_lat = lat;
                    end
                    chk("respData", respData, exp_resp_q[0]);
                    chk("respErr", {31'd0, respErr}, {31'd0, e_err});
                    if (respReady) begin
                        for (int i = 0; i < pend_n; i++) begin
                            wd = pend_d >> (8 * i);
                            ref_bytes[pend_a+i] = wd[7:0];
                        end
                        held_data = exp_resp_q.pop_front();
                        held_err  = e_err;
                        busy      = 1'b0;
                    end
                end
            end else begin
                chk("idle_memRdEnable", {31'd0, memRdEnable}, 32'd0);
                chk("idle_memWrEnable", {31'd0, memWrEnable}, 32'd0);
                chk("idle_respValid", {31'd0, respValid}, 32'd0);
                chk("idle_respData_hold", respData, held_data);
                chk("idle_respErr_hold", {31'd0, respErr}, {31'd0, held_err});
                if (reqValid && reqReady) begin
                    // Accept on the coming edge: predict this request's outcome.
                    a      = int'(reqAddr);
                    off    = a % 4;
                    nb     = (reqSize == 2'd0) ? 1 : (reqSize == 2'd1) ? 2 : 4;
                    e_err  = (reqSize == 2'd3) || (reqSize == 2'd1 && reqAddr[0]) ||
                             (reqSize == 2'd2 && reqAddr[1:0] != 2'd0);
                    e_wa   = reqAddr[AW-1:2];
                    e_load = 1'b0; e_sw = 1'b0; e_rmw = 1'b0;
                    e_data = 32'd0; e_word = 32'd0; pend_n = 0;
                    if (e_err) begin
                        e_lat = 1;
                    end else if (!reqWrite) begin
                        e_load = 1'b1;
                        e_lat  = 2;
                        v = 32'd0;
                        for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[a+i]) << (8 * i));
                        if (reqSigned && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
                        e_data = v;
                    end else begin
                        e_sw   = (nb == 4);
                        e_rmw  = (nb < 4);
                        e_lat  = e_sw ? 2 : 3;
                        pend_a = a;
                        pend_n = nb;
                        pend_d = reqWrData;
                        for (int b = 0; b < 4; b++) begin
                            bt = ref_bytes[(a - off) + b];
                            if (b >= off && b < off + nb) begin
                                wd = reqWrData >> (8 * (b - off));
                                bt = wd[7:0];
                            end
                            e_word[8*b +: 8] = bt;
                        end
                    end
                    exp_resp_q.push_back(e_data);
                    busy = 1'b1;
                    seen = 1'b0;
                    lat  = 0;
                end
            end
        end
    end

    // ---------------- response-ready driver ----------------
    bit hold_low = 1'b0;
    bit rr_rand  = 1'b0;

    always @(posedge clk) begin
        #2;
        respReady = hold_low ? 1'b0 : (rr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // ---------------- request driver tasks ----------------
    task automatic drive_req(input bit w, input logic [1:0] sz, input bit sg,
                             input logic [AW-1:0] a, input logic [31:0] d);
        reqWrite  = w;
        reqSize   = sz;
        reqSigned = sg;
        reqAddr   = a;
        reqWrData = d;
        reqValid  = 1'b1;
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (reqReady) begin
                @(posedge clk);
                #1;
                reqValid = 1'b0;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
            reqValid = 1'b0;
        end
    endtask

    task automatic wait_resp(output logic [31:0] rd, output logic er);
        bit ok = 1'b0;
        rd = 32'hX;
        er = 1'bX;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (respValid && respReady) begin
                rd = respData;
                er = respErr;
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_timeout: got no response expected response within 50 cycles");
        end
    endtask

    task automatic do_req(input bit w, input logic [1:0] sz, input bit sg,
                          input logic [AW-1:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er);
        drive_req(w, sz, sg, a, d);
        wait_accept();
        wait_resp(rd, er);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [31:0] rd, wref;
        logic        er;
        int          wp, rp;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_reqReady", {31'd0, reqReady}, 32'd1);
        chk("reset_respValid", {31'd0, respValid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: sw then lw of the same word.
        wp = wr_pulses;
        do_req(1'b1, 2'd2, 1'b0, 7'h08, 32'hDEAD_BEEF, rd, er);
        chk("t1_sw_data", rd, 32'd0);
        chk("t1_sw_lat", last_lat, 2);
        chk("t1_sw_pulses", wr_pulses - wp, 1);
        chk("t1_mem", env_mem[2], 32'hDEAD_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 7'h08, 32'd0, rd, er);
        chk("t1_lw_data", rd, 32'hDEAD_BEEF);
        chk("t1_lw_lat", last_lat, 2);

        // 2: byte store into a known word, signed and unsigned byte loads.
        do_req(1'b1, 2'd2, 1'b0, 7'h08, 32'h1122_3344, rd, er);
        do_req(1'b1, 2'd0, 1'b0, 7'h09, 32'h0000_00AA, rd, er);
        chk("t2_sb_lat", last_lat, 3);
        chk("t2_mem", env_mem[2], 32'h1122_AA44);
        do_req(1'b0, 2'd0, 1'b1, 7'h09, 32'd0, rd, er);
        chk("t2_lb", rd, 32'hFFFF_FFAA);
        do_req(1'b0, 2'd0, 1'b0, 7'h09, 32'd0, rd, er);
        chk("t2_lbu", rd, 32'h0000_00AA);

        // 3: upper halfword store, signed and unsigned half loads.
        do_req(1'b1, 2'd1, 1'b0, 7'h0A, 32'h0000_8001, rd, er);
        chk("t3_sh_lat", last_lat, 3);
        chk("t3_mem", env_mem[2], 32'h8001_AA44);
        do_req(1'b0, 2'd1, 1'b1, 7'h0A, 32'd0, rd, er);
        chk("t3_lh", rd, 32'hFFFF_8001);
        do_req(1'b0, 2'd1, 1'b0, 7'h0A, 32'd0, rd, er);
        chk("t3_lhu", rd, 32'h0000_8001);

        // 4: misaligned and illegal requests never touch memory.
        wp = wr_pulses;
        rp = rd_pulses;
        do_req(1'b0, 2'd2, 1'b0, 7'h06, 32'd0, rd, er);
        chk("t4_lw_err", {31'd0, er}, 32'd1);
        chk("t4_lw_data", rd, 32'd0);
        chk("t4_lw_lat", last_lat, 1);
        do_req(1'b0, 2'd1, 1'b0, 7'h05, 32'd0, rd, er);
        chk("t4_lh_err", {31'd0, er}, 32'd1);
        chk("t4_lh_lat", last_lat, 1);
        do_req(1'b1, 2'd3, 1'b0, 7'h00, 32'h1234_5678, rd, er);
        chk("t4_sz3_err", {31'd0, er}, 32'd1);
        chk("t4_sz3_data", rd, 32'd0);
        chk("t4_no_wr", wr_pulses - wp, 0);
        chk("t4_no_rd", rd_pulses - rp, 0);

        // 5: response back-pressure while a second request waits.
        drive_req(1'b0, 2'd2, 1'b0, 7'h08, 32'd0);
        hold_low = 1'b1;
        wait_accept();
        for (int i = 0; i < 10 && !respValid; i++) @(posedge clk);
        #1;
        drive_req(1'b1, 2'd2, 1'b0, 7'h10, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_reqReady", {31'd0, reqReady}, 32'd0);
            chk("t5_respValid", {31'd0, respValid}, 32'd1);
            chk("t5_respData", respData, 32'h8001_AA44);
        end
        @(posedge clk);
        #1;
        hold_low = 1'b0;
        wait_resp(rd, er);
        chk("t5_lw_data", rd, 32'h8001_AA44);
        wait_accept();
        wait_resp(rd, er);
        chk("t5_mem", env_mem[4], 32'h1234_5678);

        // 6: reset taken in RMW_RD drops the pending byte store.
        wp = wr_pulses;
        drive_req(1'b1, 2'd0, 1'b0, 7'h09, 32'h0000_0055);
        wait_accept();
        rst_n = 1'b0;
        #1;
        chk("t6_reqReady", {31'd0, reqReady}, 32'd1);
        chk("t6_respValid", {31'd0, respValid}, 32'd0);
        chk("t6_memWrEnable", {31'd0, memWrEnable}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_no_wr", wr_pulses - wp, 0);
        chk("t6_mem", env_mem[2], 32'h8001_AA44);

        // Randomized traffic with random response back-pressure.
        rr_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [1:0]  sz;
            logic [6:0]  a;
            sz = 2'($urandom_range(0, 3));
            a  = 7'($urandom_range(0, 127));
            // Bias toward aligned addresses so most requests reach memory.
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd2) a[1:0] = 2'b00;
                if (sz == 2'd1) a[0]   = 1'b0;
            end
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd, er);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rr_rand = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++) begin
            wref = {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
            chk("final_mem", env_mem[i], wref);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
